// File: rtl/dsp_decim_pkg.sv
// Shared encodings and sizing helpers for the sample decimator.
package dsp_decim_pkg;

  localparam logic [1:0] MODE_AVG    = 2'd0;
  localparam logic [1:0] MODE_SAMPLE = 2'd1;
  localparam logic [1:0] MODE_PEAK   = 2'd2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } win_state_e;

  // Requested ratios beyond what the datapath was built for fall back to the maximum.
  function automatic int clamp_dl(input int dl, input int max_dl);
    return (dl > max_dl) ? max_dl : dl;
  endfunction

  function automatic int acc_width(input int input_width, input int max_dec_log2);
    return input_width + max_dec_log2;
  endfunction

endpackage

// File: rtl/decim_minmax.sv
// Registered signed min/max tracker; exposes next-state values so the caller
// can capture a window's extremes on the same edge that accepts its last sample.
module decim_minmax #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_i,
  input  logic                valid_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] min_d_o,
  output logic signed [W-1:0] max_d_o
);

  logic signed [W-1:0] min_q, min_d;
  logic signed [W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (valid_i) begin
      if (init_i) begin
        min_d = x_i;
        max_d = x_i;
      end else begin
        if (x_i < min_q) min_d = x_i;
        if (x_i > max_q) max_d = x_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_d_o = min_d;
  assign max_d_o = max_d;

endmodule

// File: rtl/sample_decimator.sv
// Power-of-two decimator: boxcar average, first-sample or peak-detect per window,
// with a restart strobe that re-aligns the window to a trigger.
module sample_decimator
  import dsp_decim_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int MAX_DEC_LOG2 = 8,
  parameter int DL_WIDTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          x_valid,
  input  logic signed [INPUT_WIDTH-1:0] x,
  input  logic [1:0]                    mode,
  input  logic [DL_WIDTH-1:0]           dec_log2,
  input  logic                          restart,
  output logic                          y_valid,
  output logic signed [INPUT_WIDTH-1:0] y,
  output logic signed [INPUT_WIDTH-1:0] y_min,
  output logic signed [INPUT_WIDTH-1:0] y_max
);

  localparam int AW = acc_width(INPUT_WIDTH, MAX_DEC_LOG2);
  localparam int CW = MAX_DEC_LOG2;

  win_state_e                    state_q, state_d;
  logic [1:0]                    mode_q, mode_d;
  logic [DL_WIDTH-1:0]           d_q, d_d, d_in;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic signed [AW-1:0]          acc_q, acc_d, x_ext, rnd, rsum;
  logic signed [INPUT_WIDTH-1:0] first_q, first_d, min_d, max_d, y_d;
  logic signed [INPUT_WIDTH:0]   mid_sum;
  logic                          start, last, emit, mm_init;

  logic                          y_valid_q;
  logic signed [INPUT_WIDTH-1:0] y_q, y_min_q, y_max_q;

  function automatic logic [CW-1:0] last_idx(input logic [DL_WIDTH-1:0] d);
    logic [CW:0] n;
    n = (CW+1)'(1) << d;
    return CW'(n - 1'b1);
  endfunction

  assign d_in  = DL_WIDTH'(clamp_dl(int'(dec_log2), MAX_DEC_LOG2));
  assign x_ext = {{MAX_DEC_LOG2{x[INPUT_WIDTH-1]}}, x};

  // Window sequencing: a sample accepted while empty (or alongside restart) opens a window.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    first_d = first_q;
    start   = restart || (state_q == ST_EMPTY);
    last    = 1'b0;
    emit    = 1'b0;
    mm_init = 1'b0;
    if (restart) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
    end
    if (x_valid) begin
      if (start) begin
        mode_d  = mode;
        d_d     = d_in;
        acc_d   = x_ext;
        first_d = x;
        mm_init = 1'b1;
        last    = (d_in == '0);
      end else begin
        acc_d = acc_q + x_ext;
        last  = (cnt_q == last_idx(d_q));
      end
      if (last) begin
        emit    = 1'b1;
        state_d = ST_EMPTY;
        cnt_d   = '0;
      end else begin
        state_d = ST_FILL;
        cnt_d   = start ? CW'(1) : cnt_q + 1'b1;
      end
    end
  end

  decim_minmax #(.W(INPUT_WIDTH)) u_minmax (
    .clk     (clk),
    .rst     (rst),
    .init_i  (mm_init),
    .valid_i (x_valid),
    .x_i     (x),
    .min_d_o (min_d),
    .max_d_o (max_d)
  );

  // Result uses the window's own latched config; the rounded sum cannot overflow AW.
  always_comb begin
    rnd = '0;
    if (d_d != '0) rnd = AW'(1) << (d_d - 1'b1);
    rsum    = acc_d + rnd;
    mid_sum = {min_d[INPUT_WIDTH-1], min_d} + {max_d[INPUT_WIDTH-1], max_d};
    case (mode_d)
      MODE_AVG:  y_d = INPUT_WIDTH'(rsum >>> d_d);
      MODE_PEAK: y_d = INPUT_WIDTH'(mid_sum >>> 1);
      default:   y_d = first_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      mode_q    <= MODE_AVG;
      d_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      first_q   <= '0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      y_min_q   <= '0;
      y_max_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      y_valid_q <= emit;
      if (emit) begin
        y_q     <= y_d;
        y_min_q <= min_d;
        y_max_q <= max_d;
      end
    end
  end

  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign y_min   = y_min_q;
  assign y_max   = y_max_q;

endmodule

// File: tb/tb_sample_decimator.sv
// Directed and random stimulus for sample_decimator, checked every cycle against
// a window-queue reference model.
module tb_sample_decimator;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              x_valid = 1'b0;
  logic signed [15:0] x = '0;
  logic [1:0]        mode = '0;
  logic [3:0]        dec_log2 = '0;
  logic              restart = 1'b0;
  logic              y_valid;
  logic signed [15:0] y, y_min, y_max;

  int checks = 0;
  int errors = 0;

  longint win[$];
  int     w_mode, w_d;
  longint exp_v, exp_y, exp_mn, exp_mx;

  always #5 clk = ~clk;

  sample_decimator #(
    .INPUT_WIDTH  (16),
    .MAX_DEC_LOG2 (8),
    .DL_WIDTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x        (x),
    .mode     (mode),
    .dec_log2 (dec_log2),
    .restart  (restart),
    .y_valid  (y_valid),
    .y        (y),
    .y_min    (y_min),
    .y_max    (y_max)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: collect the window's samples, evaluate once N are present.
  task automatic model_window();
    longint sum, mn, mx, avg;
    sum = 0;
    mn  = win[0];
    mx  = win[0];
    foreach (win[k]) begin
      sum += win[k];
      if (win[k] < mn) mn = win[k];
      if (win[k] > mx) mx = win[k];
    end
    avg = (w_d == 0) ? sum : ((sum + (longint'(1) << (w_d - 1))) >>> w_d);
    exp_mn = mn;
    exp_mx = mx;
    case (w_mode)
      0:       exp_y = avg;
      2:       exp_y = (mn + mx) >>> 1;
      default: exp_y = win[0];
    endcase
  endtask

  task automatic step(input bit r, input bit xv, input int xs, input int md, input int dl, input bit rs);
    rst      = r;
    x_valid  = xv;
    x        = 16'(xs);
    mode     = 2'(md);
    dec_log2 = 4'(dl);
    restart  = rs;
    if (r) begin
      win.delete();
      exp_v = 0; exp_y = 0; exp_mn = 0; exp_mx = 0;
    end else begin
      exp_v = 0;
      if (rs) win.delete();
      if (xv) begin
        if (win.size() == 0) begin
          w_mode = md;
          w_d    = (dl > 8) ? 8 : dl;
        end
        win.push_back(longint'(xs));
        if (win.size() == (1 << w_d)) begin
          model_window();
          exp_v = 1;
          win.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check("y_valid", y_valid, exp_v);
    check("y", y, exp_y);
    check("y_min", y_min, exp_mn);
    check("y_max", y_max, exp_mx);
    $display("t=%0t rst=%0b xv=%0b x=%0d mode=%0d dl=%0d rs=%0b -> y_valid=%0b y=%0d min=%0d max=%0d",
             $time, r, xv, xs, md, dl, rs, y_valid, y, y_min, y_max);
  endtask

  initial begin
    logic signed [15:0] r16;
    int xs, md, dl;
    bit r, xv, rs;

    // Reset held while samples arrive
    repeat (3) step(1, 1, 100, 0, 2, 0);

    // AVG, ratio 4
    step(0, 1, 1, 0, 2, 0);
    step(0, 1, 2, 0, 2, 0);
    step(0, 1, 3, 0, 2, 0);
    step(0, 1, 4, 0, 2, 0);
    check("avg1_y", y, 3);
    check("avg1_min", y_min, 1);
    check("avg1_max", y_max, 4);
    step(0, 1, -1, 0, 2, 0);
    step(0, 1, -2, 0, 2, 0);
    step(0, 1, -2, 0, 2, 0);
    step(0, 1, -2, 0, 2, 0);
    check("avg2_y", y, -2);
    step(0, 0, 0, 0, 2, 0);

    // PEAK then SAMPLE on the same data
    step(0, 1, 5, 2, 2, 0);
    step(0, 1, -3, 2, 2, 0);
    step(0, 1, 9, 2, 2, 0);
    step(0, 1, 0, 2, 2, 0);
    check("peak_y", y, 3);
    step(0, 1, 5, 1, 2, 0);
    step(0, 1, -3, 1, 2, 0);
    step(0, 1, 9, 1, 2, 0);
    step(0, 1, 0, 1, 2, 0);
    check("sample_y", y, 5);

    // Gapped input, ratio 2
    step(0, 1, 7, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 8, 0, 1, 0);
    check("gap_y", y, 8);
    step(0, 0, 0, 0, 1, 0);

    // Restart discards a partial window
    step(0, 1, 100, 0, 2, 0);
    step(0, 1, 100, 0, 2, 0);
    step(0, 1, 4, 0, 2, 1);
    step(0, 1, 4, 0, 2, 0);
    step(0, 1, 4, 0, 2, 0);
    step(0, 1, 4, 0, 2, 0);
    check("restart_y", y, 4);
    step(0, 0, 0, 0, 2, 0);

    // Config change mid-window applies at the next boundary
    step(0, 1, 10, 0, 2, 0);
    step(0, 1, 10, 0, 2, 0);
    step(0, 1, 10, 0, 0, 0);
    step(0, 1, 10, 0, 0, 0);
    check("midcfg_y", y, 10);
    step(0, 1, -77, 0, 0, 0);
    check("d0_y", y, -77);
    step(0, 1, 31000, 0, 0, 0);

    // dec_log2 above range clamps to a 256-sample window
    for (int i = 0; i < 256; i++) begin
      r16 = 16'($urandom);
      step(0, 1, int'(r16), 0, 15, 0);
    end
    step(0, 0, 0, 0, 15, 0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      xv  = ($urandom_range(0, 3) != 0);
      r16 = 16'($urandom);
      xs  = int'(r16);
      md  = int'($urandom_range(0, 3));
      dl  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(0, 3));
      rs  = ($urandom_range(0, 39) == 0);
      step(r, xv, xs, md, dl, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_decimator.md
Name: sample_decimator

Overview:
- Downstream stage of the IIR filter in the acquisition path. Consumes the filtered sample stream at full clock rate and reduces it by a runtime power-of-two ratio for capture memory and display.
- Three decimation modes, as on a scope front panel:
  - boxcar average (hi-res),
  - plain sample (first of window),
  - peak detect (min/max of window).
- A restart strobe re-aligns the window to a trigger event.

Parameters:
- INPUT_WIDTH, 16, signed input sample width. Matches the filter OUTPUT_WIDTH.
- MAX_DEC_LOG2, 8, largest supported log2 decimation ratio. Ratio range is 1..256.
- DL_WIDTH, 4, width of dec_log2. Must satisfy DL_WIDTH >= clog2(MAX_DEC_LOG2+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- x_valid  in  1  input sample strobe. Tie high for continuous streams.
- x  in  INPUT_WIDTH  signed input sample.
- mode  in  2  decimation mode: 0 = AVG, 1 = SAMPLE, 2 = PEAK, 3 = reserved (treated as SAMPLE).
- dec_log2  in  DL_WIDTH  log2 decimation ratio. Values above MAX_DEC_LOG2 clamp to MAX_DEC_LOG2.
- restart  in  1  single-cycle strobe: abandon the current window and start a new one.
- y_valid  out  1  one-cycle strobe: y, y_min and y_max are valid.
- y  out  INPUT_WIDTH  signed result. AVG: rounded mean. SAMPLE: first sample. PEAK: midpoint (y_min+y_max)>>>1.
- y_min  out  INPUT_WIDTH  signed window minimum. Updated in every mode.
- y_max  out  INPUT_WIDTH  signed window maximum. Updated in every mode.

Behaviour:
- Reset, effective at the clock edge with rst=1:
  - y_valid=0, y=0, y_min=0, y_max=0;
  - accumulator, sample counter, min/max trackers and first-sample register cleared;
  - window state = EMPTY.
  - rst takes precedence over restart and x_valid.
- Window configuration:
  - mode and clamped dec_log2 are latched as d into a shadow register on the first accepted sample of each window.
  - Changes mid-window take effect at the next window boundary.
  - Window length is N = 2^d accepted samples. Cycles with x_valid=0 do not count.
- States:
  - EMPTY --(x_valid)--> FILL, or straight to EMPTY-with-output when N=1.
  - FILL --(x_valid and count==N-1)--> EMPTY, and emit a result.
  - restart in any state --> EMPTY.
- Accumulator:
  - Signed, INPUT_WIDTH+MAX_DEC_LOG2 bits, sign-extended adds.
  - No overflow is possible by construction.
- AVG rounding:
  - y = (acc + 2^(d-1)) >>> d, i.e. round-half-up.
  - For d=0, y=x.
  - The result always fits INPUT_WIDTH because the mean lies in the input range. No saturation logic.
- Min/max:
  - The first sample of the window initialises both trackers.
  - Subsequent samples use signed compare.
- Latency and output timing:
  - y_valid asserts in the cycle after the clock edge that accepts the Nth sample.
  - y_valid lasts exactly one cycle.
  - Outputs hold their values until the next y_valid. They do not return to 0.
- Back-to-back windows:
  - A sample accepted in the cycle y_valid is high starts the next window.
  - No sample is dropped. Continuous input gives exactly one y_valid every N cycles.
- restart:
  - Discards any partial window; no output is emitted for it.
  - If x_valid is high in the same cycle, that sample becomes sample 0 of the new window, using the mode/dec_log2 present in that cycle.
  - A y_valid already scheduled for the current cycle still occurs.
- Counter:
  - Width MAX_DEC_LOG2.
  - Compared against (2^d)-1 using the shadow d.
  - Wraps to 0 at each window end.

Decomposition:
- Package dsp_decim_pkg holds:
  - mode encodings MODE_AVG=2'd0, MODE_SAMPLE=2'd1, MODE_PEAK=2'd2;
  - the DL clamp function;
  - the accumulator-width constant function INPUT_WIDTH+MAX_DEC_LOG2.
- Optional sub-module decim_minmax:
  - registered signed min/max tracker;
  - inputs init and valid.
- Everything else stays in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles while x_valid=1 and x=100 -> y_valid=0 and y=y_min=y_max=0 throughout. The first window starts on the first sample after rst falls.
- AVG, dec_log2=2, continuous 1,2,3,4 then -1,-2,-2,-2 -> first y_valid 1 cycle after sample 4 with y=3 (y_min=1, y_max=4). Second y_valid exactly 4 cycles later with y=-2 ((-7+2)>>>2).
- PEAK, dec_log2=2, samples 5,-3,9,0 -> y_min=-3, y_max=9, y=3. SAMPLE mode on the same data -> y=5.
- Gapped input, AVG, dec_log2=1: x_valid pattern 1,0,0,1 carrying samples 7 and 8 -> a single y_valid 1 cycle after the second valid sample, y=8 ((15+1)>>1).
- restart: AVG, dec_log2=2, two samples of 100, then restart with x_valid=1 and x=4, then 4,4,4 -> no output for the partial window. One y_valid with y=4.
- Mid-window config change: dec_log2 switches 2->0 after the 2nd sample of a window of 10s -> that window completes with 4 samples (y=10). Every subsequent sample then yields y_valid with y=x. dec_log2=15 behaves as 8 (256-sample window).
